// File: rtl/stack_pkg.sv
// Shared definitions for the data and return stacks: op encodings and default widths.
package stack_pkg;

  localparam int unsigned STACK_WIDTH = 16;
  localparam int unsigned STACK_DEPTH = 32;
  localparam int unsigned STACK_OP_W  = 3;

  // Stack operation codes issued by the instruction decoder; 6 and 7 act as NONE.
  typedef enum logic [STACK_OP_W-1:0] {
    OP_NONE   = 3'd0,
    OP_PUSH   = 3'd1,
    OP_POPREP = 3'd2,
    OP_POP    = 3'd3,
    OP_POP2   = 3'd4,
    OP_SWAP   = 3'd5
  } stack_op_e;

  // Address width for an array of n entries, never narrower than one bit.
  function automatic int unsigned addr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stack_regfile.sv
// Backing storage for entries below NOS: one synchronous write port, two combinational reads.
module stack_regfile
  import stack_pkg::*;
#(
  parameter int unsigned WIDTH = STACK_WIDTH,
  parameter int unsigned NUM   = STACK_DEPTH - 2,
  parameter int unsigned AW    = addr_width(NUM)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr0_i,
  input  logic [AW-1:0]    raddr1_i,
  output logic [WIDTH-1:0] rdata0_o,
  output logic [WIDTH-1:0] rdata1_o
);

  logic [WIDTH-1:0] mem_q [NUM];

  // Spill write; contents are don't-care after reset so no reset branch.
  always_ff @(posedge clk) begin
    if (we_i && (32'(waddr_i) < NUM)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Combinational reads; addresses outside the array read as zero.
  always_comb begin
    rdata0_o = '0;
    rdata1_o = '0;
    if (32'(raddr0_i) < NUM) rdata0_o = mem_q[raddr0_i];
    if (32'(raddr1_i) < NUM) rdata1_o = mem_q[raddr1_i];
  end

endmodule

// File: rtl/stack_unit.sv
// Data stack: TOS/NOS held in registers, deeper entries spilled to stack_regfile.
module stack_unit
  import stack_pkg::*;
#(
  parameter int unsigned WIDTH = STACK_WIDTH,
  parameter int unsigned DEPTH = STACK_DEPTH,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [STACK_OP_W-1:0] stackOP,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  err_clr,
  output logic [WIDTH-1:0]      tos,
  output logic [WIDTH-1:0]      nos,
  output logic [CW-1:0]         count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned NUM = DEPTH - 2;
  localparam int unsigned AW  = addr_width(NUM);

  logic [WIDTH-1:0] tos_q, tos_d;
  logic [WIDTH-1:0] nos_q, nos_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic             spill_we;
  logic [AW-1:0]    spill_addr;
  logic [AW-1:0]    rd0_addr;
  logic [AW-1:0]    rd1_addr;
  logic [WIDTH-1:0] rd0_data;
  logic [WIDTH-1:0] rd1_data;
  logic             ge2, ge3, ge4;

  assign ge2 = (cnt_q >= CW'(2));
  assign ge3 = (cnt_q >= CW'(3));
  assign ge4 = (cnt_q >= CW'(4));

  // Spill slot is count-2; the file's top is count-3 and the one below it count-4.
  assign spill_addr = AW'(cnt_q - CW'(2));
  assign rd0_addr   = AW'(cnt_q - CW'(3));
  assign rd1_addr   = AW'(cnt_q - CW'(4));

  stack_regfile #(
    .WIDTH (WIDTH),
    .NUM   (NUM),
    .AW    (AW)
  ) u_regfile (
    .clk      (clk),
    .we_i     (spill_we),
    .waddr_i  (spill_addr),
    .wdata_i  (nos_q),
    .raddr0_i (rd0_addr),
    .raddr1_i (rd1_addr),
    .rdata0_o (rd0_data),
    .rdata1_o (rd1_data)
  );

  // Op decode: legal ops update TOS/NOS/count, shortfalls only raise a sticky flag.
  always_comb begin
    tos_d    = tos_q;
    nos_d    = nos_q;
    cnt_d    = cnt_q;
    ovf_d    = err_clr ? 1'b0 : ovf_q;
    unf_d    = err_clr ? 1'b0 : unf_q;
    spill_we = 1'b0;
    if (en) begin
      case (stackOP)
        OP_PUSH: begin
          if (cnt_q == CW'(DEPTH)) begin
            ovf_d = 1'b1;
          end else begin
            spill_we = ge2;
            nos_d    = tos_q;
            tos_d    = wdata;
            cnt_d    = cnt_q + CW'(1);
          end
        end
        OP_POP: begin
          if (cnt_q == '0) begin
            unf_d = 1'b1;
          end else begin
            tos_d = nos_q;
            nos_d = ge3 ? rd0_data : '0;
            cnt_d = cnt_q - CW'(1);
          end
        end
        OP_POPREP: begin
          if (!ge2) begin
            unf_d = 1'b1;
          end else begin
            tos_d = wdata;
            nos_d = ge3 ? rd0_data : '0;
            cnt_d = cnt_q - CW'(1);
          end
        end
        OP_POP2: begin
          if (!ge2) begin
            unf_d = 1'b1;
          end else begin
            tos_d = ge3 ? rd0_data : '0;
            nos_d = ge4 ? rd1_data : '0;
            cnt_d = cnt_q - CW'(2);
          end
        end
        OP_SWAP: begin
          if (!ge2) begin
            unf_d = 1'b1;
          end else begin
            tos_d = nos_q;
            nos_d = tos_q;
          end
        end
        default: ;
      endcase
    end
    empty_d = (cnt_d == '0);
    full_d  = (cnt_d == CW'(DEPTH));
  end

  // State and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tos_q   <= '0;
      nos_q   <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      tos_q   <= tos_d;
      nos_q   <= nos_d;
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign tos       = tos_q;
  assign nos       = nos_q;
  assign count     = cnt_q;
  assign empty     = empty_q;
  assign full      = full_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: doc/stack_unit.md
Name: stack_unit

Overview:
- Data-stack responder for the stack processor. Executes the 3-bit stack operation code issued by the instruction decoder each cycle.
- Holds top-of-stack (TOS) and next-of-stack (NOS) in dedicated registers and spills deeper entries to a backing register file.
- Supplies TOS/NOS to the ALU, branch compare and memory-write paths. Reports full/empty status and sticky overflow/underflow errors.

Parameters:
- WIDTH, 16, data word width.
- DEPTH, 32, maximum number of entries (including TOS and NOS); must be >= 3.
- CW, $clog2(DEPTH+1), width of the count output.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  operation enable; low = hold all state (halt/stall).
- stackOP  input  3  0 NONE, 1 PUSH, 2 POPANDREPLACE, 3 POP, 4 POP2, 5 SWAP; codes 6 and 7 are treated as NONE.
- wdata  input  WIDTH  value written by PUSH / POPANDREPLACE (from the ALU/imm/mem/input mux).
- err_clr  input  1  synchronous clear of sticky error flags.
- tos  output  WIDTH  registered top entry; 0 when count==0.
- nos  output  WIDTH  registered second entry; 0 when count<2.
- count  output  CW  current number of valid entries.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- overflow  output  1  sticky flag: a PUSH was attempted while full.
- underflow  output  1  sticky flag: an op was attempted with insufficient entries.

Behaviour:
- Reset (reset low, asynchronous): count=0, tos=0, nos=0, overflow=0, underflow=0, backing file contents don't-care. empty=1, full=0.
- All updates occur on the rising clk edge when en=1. Results are visible the cycle after the op is presented (1-cycle latency). tos/nos are never combinational from stackOP.
- en=0: no state change, including the error flags; err_clr is still honoured.
- Backing file: count-2 live entries, with a spill pointer equal to count-2 when count>=2. Deeper entry reads are combinational; writes are synchronous.
- NONE: no change.
- PUSH:
  - Requires count<DEPTH.
  - Effect: nos<=tos; if count>=2, spill old nos to file[count-2]; tos<=wdata; count+1.
- POP:
  - Requires count>=1.
  - Effect: tos<=nos; nos<=file[count-3] if count>=3, else 0; count-1.
- POPANDREPLACE:
  - Requires count>=2. Used for binary ALU ops that consume TOS and NOS and push the result.
  - Effect: tos<=wdata; nos<=file[count-3] if count>=3, else 0; count-1.
- POP2:
  - Requires count>=2.
  - Effect: tos<=file[count-3] if count>=3, else 0; nos<=file[count-4] if count>=4, else 0; count-2.
- SWAP:
  - Requires count>=2.
  - Effect: tos<=nos, nos<=tos; count unchanged.
- Illegal attempt (requirement not met): the op is suppressed with no state change except that the flag sets. PUSH when full sets overflow; all other shortfalls set underflow.
- Error flags are sticky until reset or err_clr. If err_clr and a new error occur in the same cycle, the new error wins (flag=1).
- wdata is sampled only for PUSH and POPANDREPLACE.
- Vacated tos/nos slots are loaded with 0, so an empty stack always reads 0/0.
- Reset asserted mid-operation aborts the op immediately. The first op after reset release sees count=0.

Decomposition:
- Shared package stack_pkg holds:
  - stackOP encodings (NONE..SWAP), shared with the decoder and with the return stack.
  - Width constants.
- One sub-module, stack_regfile: DEPTH-2 x WIDTH array with one synchronous write port and two combinational read ports (addresses count-3 and count-4).
- The op decode, count and the tos/nos registers stay in stack_unit.

Test Plan:
- Reset then PUSH 0x0011, PUSH 0x0022, PUSH 0x0033 -> tos=0x0033, nos=0x0022, count=3. Then POP -> tos=0x0022, nos=0x0011, count=2.
- With stack holding 0x0005, 0x0007 (tos=0x0007): POPANDREPLACE with wdata=0x000C -> tos=0x000C, nos=0, count=1. Then SWAP -> underflow=1, tos=0x000C, count=1.
- Push 1..5, then POP2 -> tos=3, nos=2, count=3. SWAP -> tos=2, nos=3.
- Fill to DEPTH=32 with values 0..31 -> full=1. PUSH 0xFFFF -> overflow=1, tos=31, count=32. Pop all 32 -> values 31..0 in order, empty=1, tos=0, nos=0.
- en=0 with PUSH 0x1234 for 3 cycles -> count, tos and nos unchanged. err_clr pulse with a concurrent POP on empty -> underflow remains 1.
- Assert reset asynchronously mid-cycle with count=4 -> outputs are 0 and empty=1 before the next clk edge. After release, PUSH 0x00AA -> tos=0x00AA, count=1.
